// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART receive path.
//   UART_DATA_W / RX_ENTRY_W : byte width and stored entry width (ferr + data)
//   rx_entry_t              : one FIFO entry, {ferr, data}
//   RX_FIFO_*               : default depth, threshold and character timeout
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int RX_ENTRY_W  = 9;

    localparam int RX_FIFO_DEPTH    = 16;
    localparam int RX_FIFO_THRESH   = 8;
    localparam int RX_TIMEOUT_TICKS = 64;

    typedef struct packed {
        logic                   ferr;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_sync_fifo_mem.sv
// uart_sync_fifo_mem: DEPTH x RX_ENTRY_W storage for the receive FIFO.
// Ports:
//   clk, reset      : clock, async active-high reset (clears contents so the
//                     head reads as zero out of reset)
//   we, waddr, wdata: synchronous write port
//   raddr, rdata    : asynchronous read port
module uart_sync_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [RX_ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [RX_ENTRY_W-1:0] rdata
);

    logic [RX_ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte buffer between the UART receiver and the APB
// register block. Captures {~stop_bit, data} on each rising edge of rx_done
// into a DEPTH-entry circular FIFO, drained by single-cycle pop strobes.
// Ports:
//   clk, reset                    : clock, async active-high reset
//   rx_done, rx_stop_bit, rx_data : receiver handshake and byte
//   i_clk_rx                      : rx baud tick (character timeout only)
//   pop, flush, ovr_clr           : register-block controls
//   rd_data, rd_ferr              : head entry (first-word fall-through)
//   empty, full, count            : fill status (registered)
//   overrun                       : sticky dropped-byte flag
//   thr_irq, timeout_irq          : interrupt conditions
// Build option: define RX_TIMEOUT_EN to build the character-timeout counter;
// otherwise timeout_irq is tied low and i_clk_rx is ignored.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH         = RX_FIFO_DEPTH,
    parameter int AW            = $clog2(DEPTH),
    parameter int THRESH        = RX_FIFO_THRESH,
    parameter int TIMEOUT_TICKS = RX_TIMEOUT_TICKS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_done,
    input  logic                   rx_stop_bit,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   i_clk_rx,
    input  logic                   pop,
    input  logic                   flush,
    input  logic                   ovr_clr,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_ferr,
    output logic                   empty,
    output logic                   full,
    output logic [AW:0]            count,
    output logic                   overrun,
    output logic                   thr_irq,
    output logic                   timeout_irq
);

    localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0] CNT_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_THRESH = (AW+1)'(THRESH);

    logic          rx_done_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_nxt;
    logic          push_edge;
    logic          do_push;
    logic          do_pop;
    logic          drop;
    logic          mem_we;
    rx_entry_t     wr_entry;
    rx_entry_t     head;

    assign push_edge = rx_done & ~rx_done_q;
    assign do_pop    = pop & ~empty;
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign do_push   = push_edge & (~full | do_pop);
    assign drop      = push_edge & full & ~do_pop;
    assign mem_we    = do_push & ~flush;

    assign wr_entry.ferr = ~rx_stop_bit;
    assign wr_entry.data = rx_data;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_nxt = count + CNT_ONE;
                2'b01:   count_nxt = count - CNT_ONE;
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_done_q <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            thr_irq   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
            count     <= count_nxt;
            empty     <= (count_nxt == '0);
            full      <= (count_nxt == CNT_DEPTH);
            thr_irq   <= (count_nxt >= CNT_THRESH);
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                overrun <= 1'b0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                // A new drop outranks a clear in the same cycle.
                if (drop)         overrun <= 1'b1;
                else if (ovr_clr) overrun <= 1'b0;
            end
        end
    end

    uart_sync_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign rd_data = head.data;
    assign rd_ferr = head.ferr;

`ifdef RX_TIMEOUT_EN
    localparam int             TW     = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0]  TO_MAX = TW'(TIMEOUT_TICKS);

    logic [TW-1:0] idle_cnt;
    logic [TW-1:0] idle_nxt;
    logic          timeout_q;

    // Idle time only accumulates while data sits untouched in the FIFO.
    always_comb begin
        idle_nxt = idle_cnt;
        if (flush | push_edge | do_pop | empty) begin
            idle_nxt = '0;
        end else if (i_clk_rx && (idle_cnt != TO_MAX)) begin
            idle_nxt = idle_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_cnt <= idle_nxt;
            if (flush | do_pop)          timeout_q <= 1'b0;
            else if (idle_nxt == TO_MAX) timeout_q <= 1'b1;
        end
    end

    assign timeout_irq = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = i_clk_rx | (TIMEOUT_TICKS < 1);
    assign timeout_irq = 1'b0;
`endif

endmodule
